wb_arb2_ctrl: RTL and testbench
===============================

Name: wb_arb2_ctrl

Overview:
- Two-master to one-slave Wishbone (pipelined) arbiter and sequencer in front of a generated register bank.
- Typical masters: a host bridge and a local config engine, sharing the bank's single Wishbone slave port.
- One transaction is in flight at a time; the two masters get round-robin fairness.
- A watchdog returns err to the owning master if the slave never responds.

Parameters:
- ADR_W, 30: address width on both sides (word address bits).
- TIMEOUT, 255: maximum cycles from slave-side issue to response before a forced err; range 2..65535.
- TMO_W, 16: timeout counter width; must hold TIMEOUT.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- m0_cyc_i / m1_cyc_i  in  1  master bus cycle.
- m0_stb_i / m1_stb_i  in  1  master strobe.
- m0_adr_i / m1_adr_i  in  ADR_W  master address.
- m0_sel_i / m1_sel_i  in  4  byte selects.
- m0_we_i / m1_we_i  in  1  write enable.
- m0_dat_i / m1_dat_i  in  32  write data.
- m0_ack_o / m1_ack_o  out  1  response ack, one-cycle pulse.
- m0_err_o / m1_err_o  out  1  response err (slave err or timeout), one-cycle pulse.
- m0_stall_o / m1_stall_o  out  1  request not accepted this cycle.
- m0_dat_o / m1_dat_o  out  32  read data, valid with ack.
- s_cyc_o, s_stb_o  out  1 each  slave cycle and strobe.
- s_adr_o  out  ADR_W  slave address.
- s_sel_o  out  4  slave byte selects.
- s_we_o  out  1  slave write enable.
- s_dat_o  out  32  slave write data.
- s_ack_i, s_err_i, s_stall_i  in  1 each  slave ack, err and stall.
- s_dat_i  in  32  slave read data.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT. Registers: owner (1 bit), last (1 bit), tmo counter.
- Request N = mN_cyc_i & mN_stb_i.
- IDLE, accepting:
  - If exactly one request is present, grant it.
  - If both are present, grant the master not equal to last.
  - Acceptance is combinational: mN_stall_o = ~(state==IDLE & grant==N). The non-granted master and every non-IDLE state give stall=1.
- On accept at cycle T:
  - adr/sel/we/dat of the granted master are latched into s_*_o.
  - owner and last are set to N; tmo is cleared.
  - s_cyc_o=1 and s_stb_o=1 from cycle T+1; state goes to ISSUE.
- ISSUE: hold s_stb_o=1 and all s_* stable while s_stall_i=1. On a cycle with s_stall_i=0, s_stb_o=0 next cycle and state goes to WAIT.
- WAIT: keep s_cyc_o=1.
  - First cycle with s_ack_i|s_err_i: register mN_ack_o or mN_err_o (owner) plus mN_dat_o=s_dat_i, visible next cycle for exactly 1 cycle.
  - On that same edge s_cyc_o=0 and state returns to IDLE. A new accept is possible in that IDLE cycle.
  - If s_ack_i and s_err_i arrive together, err wins.
- Timeout:
  - tmo increments every cycle in ISSUE and WAIT and saturates.
  - When tmo reaches TIMEOUT-1 with no response: pulse mN_err_o for the owner, drop s_cyc_o/s_stb_o, go to IDLE.
  - Response and timeout on the same cycle: the response wins.
- Stray slave ack/err in IDLE: ignored, no master output.
- Owner drops mN_cyc_i mid-transaction: the slave transaction still completes, or times out. The response pulse is suppressed (ack/err gated by the owner's cyc_i at response time).
- Latency: accept T -> s_stb_o T+1. Slave ack at cycle M -> master ack at M+1.
- Reset values (rst_i=1 at any time, including mid-transaction; takes effect the next edge):
  - state=IDLE, owner=0, last=1 (m0 wins the first tie), tmo=0.
  - s_cyc_o=0, s_stb_o=0, s_adr_o=0, s_sel_o=0, s_we_o=0, s_dat_o=0.
  - All mN_ack_o/err_o=0, mN_dat_o=0.
  - mN_stall_o follows the IDLE rule.
  - The in-flight transaction is abandoned without a response.

Test Plan:
- Single write: m0 writes adr=0x0, dat=0x12345678, sel=0xF; slave stall=0, ack 2 cycles after stb -> s_stb_o 1 cycle at T+1, m0_ack_o pulse at T+4, m1 sees nothing.
- Tie: both request from reset -> m0 granted first (m1_stall_o=1). m1 granted next IDLE even if m0 re-requests. Then alternation m0,m1,m0 over 4 transactions.
- Slave stall: s_stall_i=1 for 3 cycles -> s_stb_o held 4 cycles with s_adr_o/s_dat_o unchanged. Read returns s_dat_i=0x00000123 on m1_dat_o with m1_ack_o.
- Timeout: TIMEOUT=8, slave never acks -> owner err_o pulse 8 cycles after issue, s_cyc_o=0. A late s_ack_i two cycles later produces no master pulse.
- Simultaneous ack+err -> err_o only. Ack and timeout on the same cycle -> ack_o only.
- Reset mid-WAIT: assert rst_i for 1 cycle -> s_cyc_o=0 next cycle, no ack/err to owner, next tie grants m0.

Source files
------------

// File: rtl/wb_arb2_ctrl.sv
// Two-master round-robin Wishbone arbiter in front of a single slave port.
// Only one transaction is in flight at a time, and a watchdog forces err when the slave goes silent.
module wb_arb2_ctrl #(
    parameter int ADR_W   = 30,
    parameter int TIMEOUT = 255,
    parameter int TMO_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,

    input  logic               m0_cyc_i,
    input  logic               m0_stb_i,
    input  logic [ADR_W-1:0]   m0_adr_i,
    input  logic [3:0]         m0_sel_i,
    input  logic               m0_we_i,
    input  logic [31:0]        m0_dat_i,
    output logic               m0_ack_o,
    output logic               m0_err_o,
    output logic               m0_stall_o,
    output logic [31:0]        m0_dat_o,

    input  logic               m1_cyc_i,
    input  logic               m1_stb_i,
    input  logic [ADR_W-1:0]   m1_adr_i,
    input  logic [3:0]         m1_sel_i,
    input  logic               m1_we_i,
    input  logic [31:0]        m1_dat_i,
    output logic               m1_ack_o,
    output logic               m1_err_o,
    output logic               m1_stall_o,
    output logic [31:0]        m1_dat_o,

    output logic               s_cyc_o,
    output logic               s_stb_o,
    output logic [ADR_W-1:0]   s_adr_o,
    output logic [3:0]         s_sel_o,
    output logic               s_we_o,
    output logic [31:0]        s_dat_o,
    input  logic               s_ack_i,
    input  logic               s_err_i,
    input  logic               s_stall_i,
    input  logic [31:0]        s_dat_i
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic             owner;
    logic             last;
    logic [TMO_W-1:0] tmo;

    logic             req0;
    logic             req1;
    logic             grant_vld;
    logic             grant;
    logic             tmo_hit;
    logic [TMO_W-1:0] tmo_inc;
    logic             got_resp;
    logic             done;
    logic             owner_cyc;
    logic             pulse_ack;
    logic             pulse_err;

    // On a tie the master that did not win last time gets the bus.
    always_comb begin
        req0      = m0_cyc_i & m0_stb_i;
        req1      = m1_cyc_i & m1_stb_i;
        grant_vld = req0 | req1;
        grant     = (req0 & req1) ? ~last : req1;
    end

    assign m0_stall_o = ~((state == ST_IDLE) & grant_vld & ~grant);
    assign m1_stall_o = ~((state == ST_IDLE) & grant_vld & grant);

    // A real response beats a timeout landing on the same cycle; err beats ack.
    always_comb begin
        tmo_hit   = (tmo == TMO_LAST);
        tmo_inc   = (tmo == '1) ? tmo : tmo + TMO_W'(1);
        got_resp  = (state == ST_WAIT) & (s_ack_i | s_err_i);
        done      = got_resp
                  | ((state == ST_WAIT) & tmo_hit)
                  | ((state == ST_ISSUE) & tmo_hit);
        owner_cyc = owner ? m1_cyc_i : m0_cyc_i;
        pulse_err = ~got_resp | s_err_i;
        pulse_ack = got_resp & s_ack_i & ~s_err_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;
            tmo      <= '0;
            s_cyc_o  <= 1'b0;
            s_stb_o  <= 1'b0;
            s_adr_o  <= '0;
            s_sel_o  <= '0;
            s_we_o   <= 1'b0;
            s_dat_o  <= '0;
            m0_ack_o <= 1'b0;
            m0_err_o <= 1'b0;
            m0_dat_o <= '0;
            m1_ack_o <= 1'b0;
            m1_err_o <= 1'b0;
            m1_dat_o <= '0;
        end else begin
            m0_ack_o <= 1'b0;
            m0_err_o <= 1'b0;
            m1_ack_o <= 1'b0;
            m1_err_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        state   <= ST_ISSUE;
                        owner   <= grant;
                        last    <= grant;
                        tmo     <= '0;
                        s_cyc_o <= 1'b1;
                        s_stb_o <= 1'b1;
                        s_adr_o <= grant ? m1_adr_i : m0_adr_i;
                        s_sel_o <= grant ? m1_sel_i : m0_sel_i;
                        s_we_o  <= grant ? m1_we_i  : m0_we_i;
                        s_dat_o <= grant ? m1_dat_i : m0_dat_i;
                    end
                end
                ST_ISSUE: begin
                    tmo <= tmo_inc;
                    if (!tmo_hit && !s_stall_i) begin
                        s_stb_o <= 1'b0;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    tmo <= tmo_inc;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // A master that has dropped cyc no longer wants the answer.
            if (done) begin
                state   <= ST_IDLE;
                s_cyc_o <= 1'b0;
                s_stb_o <= 1'b0;
                if (owner_cyc) begin
                    if (owner) begin
                        m1_ack_o <= pulse_ack;
                        m1_err_o <= pulse_err;
                        if (got_resp) m1_dat_o <= s_dat_i;
                    end else begin
                        m0_ack_o <= pulse_ack;
                        m0_err_o <= pulse_err;
                        if (got_resp) m0_dat_o <= s_dat_i;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_arb2_ctrl.sv
// Self-checking bench for wb_arb2_ctrl: directed scenarios plus randomized transactions
// checked against a transaction-level model of arbitration, latency and timeout.
module tb_wb_arb2_ctrl;

    localparam int ADR_W   = 30;
    localparam int TIMEOUT = 8;
    localparam int TMO_W   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
    logic [ADR_W-1:0]  m0_adr = '0;
    logic [3:0]        m0_sel = '0;
    logic [31:0]       m0_dat = '0;
    logic              m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
    logic [ADR_W-1:0]  m1_adr = '0;
    logic [3:0]        m1_sel = '0;
    logic [31:0]       m1_dat = '0;
    logic              s_ack = 1'b0, s_err = 1'b0, s_stall = 1'b0;
    logic [31:0]       s_rdat = '0;

    logic              m0_ack_o, m0_err_o, m0_stall_o, m1_ack_o, m1_err_o, m1_stall_o;
    logic [31:0]       m0_dat_o, m1_dat_o;
    logic              s_cyc_o, s_stb_o, s_we_o;
    logic [ADR_W-1:0]  s_adr_o;
    logic [3:0]        s_sel_o;
    logic [31:0]       s_dat_o;

    int n_cmp  = 0;
    int n_fail = 0;
    bit model_last = 1'b1;

    always #5 clk = ~clk;

    wb_arb2_ctrl #(.ADR_W(ADR_W), .TIMEOUT(TIMEOUT), .TMO_W(TMO_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_adr_i(m0_adr), .m0_sel_i(m0_sel),
        .m0_we_i(m0_we), .m0_dat_i(m0_dat), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m0_stall_o(m0_stall_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_adr_i(m1_adr), .m1_sel_i(m1_sel),
        .m1_we_i(m1_we), .m1_dat_i(m1_dat), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .m1_stall_o(m1_stall_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_adr_o(s_adr_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_stall_i(s_stall), .s_dat_i(s_rdat)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        s_ack = 0; s_err = 0; s_stall = 0;
        step();
        step();
        rst = 1'b0;
        model_last = 1'b1;
    endtask

    task automatic randomize_masters();
        m0_adr = ADR_W'($urandom()); m0_sel = 4'($urandom()); m0_we = 1'($urandom()); m0_dat = $urandom();
        m1_adr = ADR_W'($urandom()); m1_sel = 4'($urandom()); m1_we = 1'($urandom()); m1_dat = $urandom();
    endtask

    // One transaction starting in the current (IDLE) cycle. The slave stalls stall_n cycles,
    // then answers ack_dly cycles after leaving ISSUE; the model predicts grant and response.
    task automatic do_txn(input bit r0, input bit r1, input int stall_n, input int ack_dly,
                          input bit ack_f, input bit err_f, input logic [31:0] rdata,
                          output int g);
        int          resp_k, end_k, done_k;
        bit          tmo;
        logic [66:0] exp_req;
        logic [3:0]  exp_p, got_p;
        bit          exp_stb, exp_cyc;
        if (r0 && r1) g = model_last ? 0 : 1;
        else          g = r1 ? 1 : 0;
        exp_req = (g == 1) ? {m1_adr, m1_sel, m1_we, m1_dat} : {m0_adr, m0_sel, m0_we, m0_dat};
        s_stall = 0; s_ack = 0; s_err = 0;
        m0_cyc = r0; m0_stb = r0; m1_cyc = r1; m1_stb = r1;
        #1;
        n_cmp++;
        if ({m0_stall_o, m1_stall_o} !== {1'(g == 1), 1'(g == 0)}) begin
            n_fail++;
            $display("[TB] FAIL accept_stall got m0/m1=%b%b want %b%b", m0_stall_o, m1_stall_o, g == 1, g == 0);
        end
        model_last = (g == 1);
        resp_k = 2 + stall_n + ack_dly;
        tmo    = resp_k > TIMEOUT;
        end_k  = tmo ? TIMEOUT : resp_k;
        done_k = end_k + 1;
        exp_p  = 4'b0000;
        if (tmo || err_f) exp_p[g*2+1] = 1'b1;
        else              exp_p[g*2]   = 1'b1;
        for (int k = 1; k <= done_k; k++) begin
            step();
            if (k == 1) begin
                m0_stb = 0; m1_stb = 0;
                if (g == 0) m1_cyc = 0; else m0_cyc = 0;
            end
            s_stall = (k <= stall_n);
            s_ack   = (k == resp_k) && ack_f;
            s_err   = (k == resp_k) && err_f;
            s_rdat  = (k == resp_k) ? rdata : $urandom();
            exp_cyc = (k <= end_k);
            exp_stb = (k <= stall_n + 1) && (k <= end_k);
            n_cmp++;
            if ({s_cyc_o, s_stb_o} !== {exp_cyc, exp_stb}) begin
                n_fail++;
                $display("[TB] FAIL slave_cyc_stb k=%0d got %b%b want %b%b", k, s_cyc_o, s_stb_o, exp_cyc, exp_stb);
            end
            if (k <= end_k) begin
                n_cmp++;
                if ({s_adr_o, s_sel_o, s_we_o, s_dat_o} !== exp_req) begin
                    n_fail++;
                    $display("[TB] FAIL slave_req k=%0d got %h want %h", k, {s_adr_o, s_sel_o, s_we_o, s_dat_o}, exp_req);
                end
            end
            if (k == 1) begin
                n_cmp++;
                if ({m0_stall_o, m1_stall_o} !== 2'b11) begin
                    n_fail++;
                    $display("[TB] FAIL busy_stall got %b%b want 11", m0_stall_o, m1_stall_o);
                end
            end
            got_p = {m1_err_o, m1_ack_o, m0_err_o, m0_ack_o};
            n_cmp++;
            if (got_p !== ((k == done_k) ? exp_p : 4'b0000)) begin
                n_fail++;
                $display("[TB] FAIL master_pulse k=%0d got %b want %b", k, got_p, (k == done_k) ? exp_p : 4'b0000);
            end
            if (k == done_k && !tmo && ack_f && !err_f) begin
                n_cmp++;
                if (((g == 1) ? m1_dat_o : m0_dat_o) !== rdata) begin
                    n_fail++;
                    $display("[TB] FAIL read_data got %h want %h", (g == 1) ? m1_dat_o : m0_dat_o, rdata);
                end
            end
        end
        s_ack = 0; s_err = 0; s_stall = 0;
        m0_cyc = 0; m1_cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if ({s_cyc_o, s_stb_o, s_adr_o, s_sel_o, s_we_o, s_dat_o} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_slave got %h want 0", {s_cyc_o, s_stb_o, s_adr_o, s_sel_o, s_we_o, s_dat_o});
        end
        n_cmp++;
        if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m0_dat_o, m1_dat_o} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_master got %h want 0", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m0_dat_o, m1_dat_o});
        end
        m1_cyc = 1; m1_stb = 1;
        #1;
        n_cmp++;
        if ({m0_stall_o, m1_stall_o} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL reset_stall_m1 got %b%b want 10", m0_stall_o, m1_stall_o);
        end
        m0_cyc = 1; m0_stb = 1;
        #1;
        n_cmp++;
        if ({m0_stall_o, m1_stall_o} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL reset_stall_tie got %b%b want 01", m0_stall_o, m1_stall_o);
        end
        apply_reset();
    endtask

    task automatic test_single_write();
        int g;
        apply_reset();
        randomize_masters();
        m0_adr = '0; m0_dat = 32'h12345678; m0_sel = 4'hF; m0_we = 1'b1;
        do_txn(1, 0, 0, 1, 1, 0, 32'hDEADBEEF, g);
    endtask

    task automatic test_tie();
        int g;
        int want [4] = '{0, 1, 0, 1};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            randomize_masters();
            do_txn(1, 1, 0, 0, 1, 0, $urandom(), g);
            n_cmp++;
            if (g !== want[i]) begin
                n_fail++;
                $display("[TB] FAIL tie_order i=%0d got m%0d want m%0d", i, g, want[i]);
            end
        end
    endtask

    task automatic test_stall_read();
        int g;
        randomize_masters();
        m1_we = 1'b0;
        do_txn(0, 1, 3, 0, 1, 0, 32'h00000123, g);
    endtask

    task automatic test_timeout();
        int g;
        randomize_masters();
        do_txn(1, 0, 0, 10, 1, 0, $urandom(), g);
        m0_cyc = 1;
        step();
        step();
        s_ack = 1;
        step();
        s_ack = 0;
        n_cmp++;
        if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_cyc_o} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL late_ack got %b want 00000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_cyc_o});
        end
        m0_cyc = 0;
        randomize_masters();
        do_txn(0, 1, 12, 0, 1, 0, $urandom(), g);
    endtask

    task automatic test_ack_err();
        int g;
        randomize_masters();
        do_txn(1, 0, 0, 1, 1, 1, $urandom(), g);
        randomize_masters();
        do_txn(0, 1, 2, 4, 1, 0, 32'hA5A5_0F0F, g);
    endtask

    task automatic test_reset_mid();
        int g;
        randomize_masters();
        m0_cyc = 1; m0_stb = 1;
        step();
        m0_stb = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        n_cmp++;
        if ({s_cyc_o, s_stb_o, m0_ack_o, m0_err_o} !== 4'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid got %b want 0000", {s_cyc_o, s_stb_o, m0_ack_o, m0_err_o});
        end
        s_ack = 1;
        step();
        s_ack = 0;
        m0_cyc = 0;
        n_cmp++;
        if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0) begin
            n_fail++;
            $display("[TB] FAIL stray_ack got %b want 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
        end
        model_last = 1'b1;
        randomize_masters();
        do_txn(1, 1, 0, 0, 1, 0, $urandom(), g);
        n_cmp++;
        if (g !== 0) begin
            n_fail++;
            $display("[TB] FAIL reset_tie got m%0d want m0", g);
        end
    endtask

    task automatic test_back_to_back();
        int g, r, mode;
        for (int i = 0; i < 24; i++) begin
            randomize_masters();
            r    = $urandom_range(1, 3);
            mode = $urandom_range(0, 3);
            do_txn(r[0], r[1], $urandom_range(0, 4), $urandom_range(0, 4),
                   mode != 2, mode >= 2, $urandom(), g);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_tie();
        test_stall_read();
        test_timeout();
        test_ack_err();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
